mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one physical memory port among up to `NUM_REQ` FPU-side memory requesters, e.g. the a/b/c/d handles of a ReLU forward/backward unit. It sits between the FPU operation FSMs and the memory controller. It serialises single-word reads and writes with a round-robin grant, and returns a one-cycle `done` pulse to the winning requester, matching the handle semantics the FPU FSMs already use.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYCLES`, 64: watchdog limit; only used with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_r_en`  in  NUM_REQ  per-requester read request; held high until that requester's `req_done`.
- `req_w_en`  in  NUM_REQ  per-requester write request; held high until `req_done`.
- `req_addr`  in  NUM_REQ×ADDR_W  per-requester word address.
- `req_wdata`  in  NUM_REQ×DATA_W  per-requester store data.
- `req_rdata`  out  DATA_W  load data; broadcast to all requesters, valid in the `req_done` cycle.
- `req_done`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `mem_r_en`  out  1  read strobe to the memory controller.
- `mem_w_en`  out  1  write strobe to the memory controller.
- `mem_addr`  out  ADDR_W  address to the memory controller.
- `mem_wdata`  out  DATA_W  store data to the memory controller.
- `mem_rdata`  in  DATA_W  load data; valid with `mem_done`.
- `mem_done`  in  1  access-complete pulse from the memory controller.
- `grant`  out  NUM_REQ  one-hot owner of the port; zero when idle.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- **IDLE:**
  - A requester `i` is eligible when `req_r_en[i] | req_w_en[i]`.
  - If any requester is eligible, pick the first eligible index searching upward from `rr_ptr` with wrap-around.
  - Latch the winner's index, op, `req_addr` and `req_wdata`, then go to BUSY.
  - If no requester is eligible, stay in IDLE.
- **Both enables high on the winner:** perform the write, set `err`.
- **BUSY:**
  - Drive `mem_r_en` or `mem_w_en` together with the latched address and data.
  - On `mem_done`: capture `mem_rdata` (reads only), drop both strobes, go to RESP.
- **RESP:**
  - Assert `req_done[grant]` and drive `req_rdata` with the captured data for one cycle.
  - Set `rr_ptr` to `grant+1` modulo `NUM_REQ`, then go to IDLE.
- **Request sampling:** request inputs are sampled only in IDLE. Changes during BUSY or RESP are ignored; the latched values are used.
- **Write data on `req_rdata`:** for writes, `req_rdata` holds the last read value.
- **Reset values:**
  - All outputs are 0: strobes, `req_done`, `grant`, `busy`, `err`, `req_rdata`, `mem_addr`, `mem_wdata`.
  - State is IDLE and `rr_ptr` is 0.
- **Reset mid-access:** the access is abandoned, no `req_done` is issued, and strobes drop asynchronously.

## Timing
- **Latency:** if a request is first high in IDLE at cycle t:
  - strobe is high from t+1;
  - `mem_done` arrives at t+1+L, where L ≥ 0 and `mem_done` may coincide with the first strobe cycle;
  - `req_done` is at t+2+L.
- **Throughput:** the minimum turnaround is 3 cycles per access (IDLE, BUSY, RESP).
- **Re-request from the same requester:**
  - The requester clears its enable on the cycle after `req_done`, so the arbiter sees the enable low in the IDLE cycle following RESP.
  - An enable still high in that IDLE cycle counts as a new request. It loses to any other eligible requester because `rr_ptr` has advanced.
- **`mem_done` outside BUSY:** ignored.
- **Single requester:** the grant goes to the sole requester every turn, with no idle bubble beyond IDLE.
- **Outputs:** `grant` and `busy` are registered. `grant` is stable from the first BUSY cycle through RESP.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` without `mem_done`:
    - drop both strobes;
    - set `err`;
    - go to RESP with `req_rdata` = 0, so the requester still receives `req_done` and does not hang.
- **Undefined:** no counter exists, and BUSY waits indefinitely for `mem_done`.

## Test plan
- **Single read:** requester 2 reads 0x100, memory returns 0xDEADBEEF with L=2 → `mem_r_en` high for 3 cycles, `req_done`=4'b0100 one cycle after `mem_done`, `req_rdata`=0xDEADBEEF.
- **Round-robin:** requesters 0, 1, 3 request simultaneously and re-request after each `done`, with `rr_ptr`=0 → grant order 0, 1, 3, 0, 1, 3; no requester is served twice consecutively while another is waiting.
- **Write:** requester 1 writes 0x3F800000 to 0x20 → `mem_w_en`=1, `mem_addr`=0x20, `mem_wdata`=0x3F800000; `req_done[1]` pulses, `err`=0.
- **Simultaneous enables:** requester 0 raises both `r_en` and `w_en` → a write is issued and `err` goes to 1 and stays there.
- **Reset in BUSY:** assert `rst` during a pending read → all outputs are 0 immediately, no `req_done` is issued; after release, requester 0 is the first one served.
- **Timeout:** with `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and `mem_done` never asserted → strobes drop after 8 BUSY cycles, `req_done` pulses with `req_rdata`=0, `err`=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-word memory port among NUM_REQ requesters.
// Optional watchdog on the memory access enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_r_en,
    input  logic [NUM_REQ-1:0]        req_w_en,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_done,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   idx_r;
    logic [NUM_REQ-1:0] elig_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [IDX_W-1:0]   rr_next_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
`endif

    assign elig_s = req_r_en | req_w_en;

    // Round-robin search: scanning downward lets the lowest offset from rr_ptr win.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig_s[(int'(rr_ptr_r) + k) % NUM_REQ]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // One-hot grant of the winner and the pointer value after the current owner.
    always_comb begin
        pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
        if (idx_r == IDX_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = idx_r + 1'b1;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            idx_r     <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            req_done  <= '0;
            req_rdata <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        idx_r     <= pick_idx_s;
                        grant     <= pick_onehot_s;
                        busy      <= 1'b1;
                        mem_addr  <= req_addr[pick_idx_s*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[pick_idx_s*DATA_W +: DATA_W];
                        // A write wins when both enables are raised; that case is flagged.
                        mem_w_en  <= req_w_en[pick_idx_s];
                        mem_r_en  <= ~req_w_en[pick_idx_s];
                        if (req_r_en[pick_idx_s] && req_w_en[pick_idx_s]) begin
                            err <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt_r <= '0;
`endif
                        state_r   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        if (mem_r_en) begin
                            req_rdata <= mem_rdata;
                        end
                        mem_r_en <= 1'b0;
                        mem_w_en <= 1'b0;
                        req_done <= grant;
                        state_r  <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_r_en  <= 1'b0;
                        mem_w_en  <= 1'b0;
                        err       <= 1'b1;
                        req_rdata <= '0;
                        req_done  <= grant;
                        state_r   <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
`endif
                end
                RESP: begin
                    req_done <= '0;
                    grant    <= '0;
                    busy     <= 1'b0;
                    rr_ptr_r <= rr_next_s;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
